add_acc_stage: RTL and testbench
================================

Name: add_acc_stage

Overview:
Registered operand-consumer stage that sits directly downstream of the x/y operand generator.
- Accepts 3-bit x/y operand pairs over a valid/ready handshake.
- Computes the full-width sum and keeps a running accumulator of all sums.
- Buffers {sum, accumulator snapshot} results in a 2-entry output queue for the next stage or checker, with backpressure in both directions.

Parameters:
W_IN, 3, operand width of x and y
W_SUM, W_IN+1, sum width (4); carry bit kept, no truncation
ACC_W, 8, running accumulator width; wraps modulo 2^ACC_W
DEPTH, 2, output queue depth; fixed at 2 for this block

Ports:
clk  in  1  single clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand pair present
in_ready  out  1  stage can accept a pair this cycle
in_x  in  W_IN  operand x
in_y  in  W_IN  operand y
acc_clr  in  1  synchronous clear of accumulator and overflow flag
out_valid  out  1  head result present
out_ready  in  1  downstream accepts head result
out_sum  out  W_SUM  head entry sum
out_acc  out  ACC_W  head entry accumulator value after its add
out_ovf  out  1  sticky: accumulator has wrapped at least once
occupancy  out  2  entries held (0..2)

Behaviour:
- Reset values: out_valid=0, occupancy=0, out_sum=0, out_acc=0, out_ovf=0, in_ready=1 (first cycle after rst deasserts). Internal accumulator=0.
- rst has priority over all other inputs. rst mid-operation discards queued entries; accepted-but-unread results are lost.
- Accept: in_valid && in_ready at a posedge.
- Sum arithmetic: sum = zero-extended in_x + zero-extended in_y, W_SUM bits. Example: 7+7=14.
- Accumulator update: acc_next = (acc + sum) mod 2^ACC_W.
- Overflow flag: out_ovf sets when that add carries out of ACC_W. It stays set until rst or acc_clr.
- Queued entry: {sum, acc_next}.
- acc_clr without accept: acc=0 and ovf=0 next cycle. Queued entries are untouched.
- acc_clr with accept in the same cycle: the add uses acc=0. acc_next = sum, and the entry carries that value. ovf=0.
- Latency: a pair accepted at edge N is visible at the output (out_valid=1) after edge N, i.e. 1 cycle; there is no combinational in->out path.
- in_ready = (occupancy != 2). A full queue never accepts, even when out_ready=1 in the same cycle; no pass-through.
- Pop: out_valid && out_ready. out_sum and out_acc hold stable while out_valid=1 and out_ready=0.
- Queue state machine (EMPTY, ONE, FULL):
  - EMPTY --push--> ONE.
  - ONE --push only--> FULL.
  - ONE --pop only--> EMPTY.
  - ONE --push+pop--> ONE, with the new entry becoming head.
  - FULL --pop--> ONE.
  - All other combinations hold state.
- Storage is a 2-slot circular buffer with a 1-bit read pointer and a 1-bit write pointer; both pointers wrap from 1 to 0.
- In EMPTY, out_sum and out_acc are don't-care; implementation drives 0.

Decomposition:
- Shared package add_pkg holds:
  - W_IN and W_SUM defaults.
  - Typedef res_t = struct {logic [W_SUM-1:0] sum; logic [ACC_W-1:0] acc;}.
  - Enum q_state_e {Q_EMPTY, Q_ONE, Q_FULL}.
- One sub-module: res_queue2, a 2-entry valid/ready queue of res_t. It owns the occupancy count and the pointers.
- The top module owns the adder, the accumulator, the overflow flag and the clear logic.

Test Plan:
- Reset then single pair x=7,y=7, out_ready=1: out_valid=1 one cycle later, out_sum=14, out_acc=14, out_ovf=0, occupancy returns to 0 after the pop.
- Backpressure: out_ready=0, drive pairs (1,2),(3,4),(5,6) back-to-back. Result: in_ready=0 after the second accept, occupancy=2, the third pair is held. Then out_ready=1: outputs come in order with sums 3, 7, 11 and accumulators 3, 10, 21.
- Wrap: 19 consecutive pairs (7,7) with ACC_W=8. The 18th entry has out_acc=252 and out_ovf=0; the 19th entry has out_acc=10 and out_ovf=1, which stays 1.
- acc_clr in the same cycle as accept of (3,2) with acc=40 and ovf=1: entry out_sum=5, out_acc=5, out_ovf=0.
- Simultaneous push+pop at occupancy=1 for 10 cycles with a random $urandom operand stream: occupancy stays 1, and each out_sum equals the x+y of the pair accepted one cycle earlier.
- rst asserted with occupancy=2 and acc=21: the next cycle has out_valid=0, occupancy=0 and in_ready=1. The following pair (2,2) gives out_acc=4.

Source files
------------

// File: rtl/add_pkg.sv
// Shared widths, result record and queue states for the add/accumulate stage.
package add_pkg;

  localparam int unsigned W_IN  = 3;
  localparam int unsigned W_SUM = W_IN + 1;
  localparam int unsigned ACC_W = 8;
  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic [W_SUM-1:0] sum;
    logic [ACC_W-1:0] acc;
  } res_t;

  // Encodings equal the entry count, so the state doubles as occupancy.
  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_e;

endpackage

// File: rtl/add_acc_stage_if.sv
// Operand input handshake plus result output handshake of the add/accumulate stage.
interface add_acc_stage_if;
  import add_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [W_IN-1:0]  in_x;
  logic [W_IN-1:0]  in_y;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [W_SUM-1:0] out_sum;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;
  logic [1:0]       occupancy;

  modport master (
    output in_valid, in_x, in_y, acc_clr, out_ready,
    input  in_ready, out_valid, out_sum, out_acc, out_ovf, occupancy
  );

  modport slave (
    input  in_valid, in_x, in_y, acc_clr, out_ready,
    output in_ready, out_valid, out_sum, out_acc, out_ovf, occupancy
  );

endinterface

// File: rtl/res_queue2.sv
// Two-entry valid/ready result queue; circular buffer with 1-bit read/write pointers.
module res_queue2
  import add_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_valid,
  output logic       push_ready,
  input  res_t       push_data,
  output logic       pop_valid,
  input  logic       pop_ready,
  output res_t       pop_data,
  output logic [1:0] occupancy
);

  q_state_e state_q, state_d;
  logic     rd_ptr_q, wr_ptr_q;
  res_t     mem_q [DEPTH];
  logic     push, pop;

  assign push_ready = (state_q != Q_FULL);
  assign pop_valid  = (state_q != Q_EMPTY);
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;
  assign occupancy  = state_q;
  assign pop_data   = (state_q == Q_EMPTY) ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Q_EMPTY: if (push) state_d = Q_ONE;
      Q_ONE: begin
        if (push && !pop)      state_d = Q_FULL;
        else if (pop && !push) state_d = Q_EMPTY;
      end
      Q_FULL:  if (pop) state_d = Q_ONE;
      default: state_d = Q_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= Q_EMPTY;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Storage needs no reset: it is only read while the state marks it valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/add_acc_stage.sv
// Adds x+y at full width, keeps a wrapping running accumulator with sticky overflow,
// and queues {sum, accumulator} results in a two-entry output queue.
module add_acc_stage
  import add_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  add_acc_stage_if.slave bus
);

  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic             accept;
  logic             q_ready;
  logic             q_valid;
  logic [1:0]       q_occ;
  logic [W_SUM-1:0] sum;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W:0]   add_full;
  res_t             push_data;
  res_t             head;

  assign accept   = bus.in_valid && q_ready;
  assign sum      = W_SUM'(bus.in_x) + W_SUM'(bus.in_y);
  // A clear in the same cycle as an accept makes that add start from zero.
  assign acc_base = bus.acc_clr ? '0 : acc_q;
  assign add_full = {1'b0, acc_base} + {{(ACC_W + 1 - W_SUM){1'b0}}, sum};

  assign push_data.sum = sum;
  assign push_data.acc = add_full[ACC_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      acc_q <= add_full[ACC_W-1:0];
      ovf_q <= (ovf_q && !bus.acc_clr) || add_full[ACC_W];
    end else if (bus.acc_clr) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end
  end

  res_queue2 u_queue (
    .clk        (clk),
    .rst        (rst),
    .push_valid (bus.in_valid),
    .push_ready (q_ready),
    .push_data  (push_data),
    .pop_valid  (q_valid),
    .pop_ready  (bus.out_ready),
    .pop_data   (head),
    .occupancy  (q_occ)
  );

  assign bus.in_ready  = q_ready;
  assign bus.out_valid = q_valid;
  assign bus.out_sum   = head.sum;
  assign bus.out_acc   = head.acc;
  assign bus.out_ovf   = ovf_q;
  assign bus.occupancy = q_occ;

endmodule

// File: tb/tb_add_acc_stage.sv
// Directed bench for add_acc_stage: queue-based reference model checked every cycle,
// plus hand-computed literal checks for the scenarios of interest.
module tb_add_acc_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;

  add_acc_stage_if bus ();

  add_acc_stage u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  int sq[$];
  int aq[$];
  int acc_m = 0;
  int ovf_m = 0;
  bit armed = 1'b0;
  bit m_push, m_pop;
  int m_sum, m_base, m_tot;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      sq.delete();
      aq.delete();
      acc_m = 0;
      ovf_m = 0;
      armed = 1'b1;
    end else if (armed) begin
      m_push = bus.in_valid && (sq.size() < 2);
      m_pop  = (sq.size() > 0) && bus.out_ready;
      m_sum  = int'(bus.in_x) + int'(bus.in_y);
      m_base = bus.acc_clr ? 0 : acc_m;
      m_tot  = m_base + m_sum;
      if (m_pop) begin
        void'(sq.pop_front());
        void'(aq.pop_front());
      end
      if (m_push) begin
        acc_m = m_tot % 256;
        ovf_m = ((bus.acc_clr ? 0 : ovf_m) != 0 || m_tot >= 256) ? 1 : 0;
        sq.push_back(m_sum);
        aq.push_back(acc_m);
      end else if (bus.acc_clr) begin
        acc_m = 0;
        ovf_m = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("model_out_valid", int'(bus.out_valid), (sq.size() != 0) ? 1 : 0);
      chk("model_occupancy", int'(bus.occupancy), sq.size());
      chk("model_in_ready", int'(bus.in_ready), (sq.size() != 2) ? 1 : 0);
      chk("model_out_ovf", int'(bus.out_ovf), ovf_m);
      chk("model_out_sum", int'(bus.out_sum), (sq.size() != 0) ? sq[0] : 0);
      chk("model_out_acc", int'(bus.out_acc), (aq.size() != 0) ? aq[0] : 0);
    end
  end

  task automatic drive(input bit v, input int x, input int y, input bit clr, input bit rdy);
    bus.in_valid  = v;
    bus.in_x      = 3'(x);
    bus.in_y      = 3'(y);
    bus.acc_clr   = clr;
    bus.out_ready = rdy;
  endtask

  int rx, ry;

  initial begin
    drive(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_occupancy", int'(bus.occupancy), 0);
    chk("reset_in_ready", int'(bus.in_ready), 1);
    chk("reset_out_sum", int'(bus.out_sum), 0);
    chk("reset_out_acc", int'(bus.out_acc), 0);
    chk("reset_out_ovf", int'(bus.out_ovf), 0);

    // Single pair 7+7.
    drive(1, 7, 7, 0, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 1);
    chk("single_valid", int'(bus.out_valid), 1);
    chk("single_sum", int'(bus.out_sum), 14);
    chk("single_acc", int'(bus.out_acc), 14);
    chk("single_ovf", int'(bus.out_ovf), 0);
    @(negedge clk);
    chk("single_drained", int'(bus.occupancy), 0);

    // Backpressure with three back-to-back pairs, accumulator cleared on the first.
    drive(1, 1, 2, 1, 0);
    @(negedge clk);
    chk("bp_head_sum", int'(bus.out_sum), 3);
    chk("bp_head_acc", int'(bus.out_acc), 3);
    drive(1, 3, 4, 0, 0);
    @(negedge clk);
    chk("bp_full_ready", int'(bus.in_ready), 0);
    chk("bp_full_occ", int'(bus.occupancy), 2);
    drive(1, 5, 6, 0, 0);
    @(negedge clk);
    chk("bp_held_occ", int'(bus.occupancy), 2);
    chk("bp_held_sum", int'(bus.out_sum), 3);
    drive(1, 5, 6, 0, 1);
    @(negedge clk);
    chk("bp_second_sum", int'(bus.out_sum), 7);
    chk("bp_second_acc", int'(bus.out_acc), 10);
    @(negedge clk);
    drive(0, 0, 0, 0, 1);
    chk("bp_third_sum", int'(bus.out_sum), 11);
    chk("bp_third_acc", int'(bus.out_acc), 21);
    @(negedge clk);
    chk("bp_drained", int'(bus.occupancy), 0);

    // Accumulator wrap: 19 x (7+7) starting from a clear.
    for (int i = 1; i <= 19; i++) begin
      drive(1, 7, 7, (i == 1), 1);
      @(negedge clk);
      if (i == 18) begin
        chk("wrap18_acc", int'(bus.out_acc), 252);
        chk("wrap18_ovf", int'(bus.out_ovf), 0);
      end
      if (i == 19) begin
        chk("wrap19_acc", int'(bus.out_acc), 10);
        chk("wrap19_ovf", int'(bus.out_ovf), 1);
      end
    end
    drive(0, 0, 0, 0, 1);
    repeat (3) @(negedge clk);
    chk("wrap_ovf_sticky", int'(bus.out_ovf), 1);

    // Bring acc to 40 (10+14+14+2), then clear together with accept of 3+2.
    drive(1, 7, 7, 0, 1);
    @(negedge clk);
    @(negedge clk);
    drive(1, 1, 1, 0, 1);
    @(negedge clk);
    chk("pre_clr_acc", int'(bus.out_acc), 40);
    chk("pre_clr_ovf", int'(bus.out_ovf), 1);
    drive(1, 3, 2, 1, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 1);
    chk("clr_accept_sum", int'(bus.out_sum), 5);
    chk("clr_accept_acc", int'(bus.out_acc), 5);
    chk("clr_accept_ovf", int'(bus.out_ovf), 0);
    @(negedge clk);

    // Push+pop at occupancy 1 with random operands.
    drive(1, 1, 1, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rx = int'($urandom_range(0, 7));
      ry = int'($urandom_range(0, 7));
      drive(1, rx, ry, 0, 1);
      @(negedge clk);
      chk("pp_occ", int'(bus.occupancy), 1);
      chk("pp_sum", int'(bus.out_sum), rx + ry);
    end
    drive(0, 0, 0, 0, 1);
    @(negedge clk);

    // Reset while full with acc=21.
    drive(1, 1, 2, 1, 1);
    @(negedge clk);
    drive(1, 3, 4, 0, 1);
    @(negedge clk);
    drive(1, 5, 6, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    chk("prerst_occ", int'(bus.occupancy), 2);
    chk("prerst_acc", int'(bus.out_acc), 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_occ", int'(bus.occupancy), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    drive(1, 2, 2, 0, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 1);
    chk("post_rst_acc", int'(bus.out_acc), 4);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
